// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
//   Bundles the N requester valid/ready/data lanes and the single registered
//   output valid/ready port of the round-robin mux arbiter.
//   Parameters: N requesters, W data bits, IW select-index bits.
//   Signals:
//     req_vld  [N]    requester i offers a word
//     req_data [N*W]  word of requester i at [i*W +: W]
//     req_rdy  [N]    requester i's word is taken this cycle (one-hot or zero)
//     out_vld         output register holds a valid word
//     out_data [W]    registered word
//     out_src  [IW]   index of the requester that produced out_data
//     out_rdy         consumer accepts out_data this cycle
//   Modports: master = producers + consumer side, slave = arbiter side.
interface mux_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_rdy;
  logic           out_vld;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_src;
  logic           out_rdy;

  modport master (
    output req_vld, req_data, out_rdy,
    input  req_rdy, out_vld, out_data, out_src
  );

  modport slave (
    input  req_vld, req_data, out_rdy,
    output req_rdy, out_vld, out_data, out_src
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter steering one shared N:1 data mux into a registered
//   valid/ready output stage. One word per cycle throughput; a word taken via
//   req_rdy in cycle t is presented on out_vld/out_data in cycle t+1.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    mux_rr_arbiter_if.slave (requester lanes + output port)
module mux_rr_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  mux_rr_arbiter_if.slave bus
);

  localparam int IWP = IW + 1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [IW-1:0]          ptr_r;
  logic [IW-1:0]          ptr_nxt_s;
  logic [IW-1:0]          grant_s;
  logic [IW-1:0]          out_src_r;
  logic [W-1:0]           out_data_r;
  logic [(1<<IW)-1:0]     vld_ext_s;
  logic [IWP-1:0]         cand_s;
  logic                   found_s;
  logic                   load_s;
  logic [N-1:0]           req_rdy_s;

  // Round-robin winner search starting at ptr; wraps modulo N, so for a
  // non-power-of-two N the unused high indices are never candidates.
  always_comb begin
    vld_ext_s        = '0;
    vld_ext_s[N-1:0] = bus.req_vld;
    found_s          = 1'b0;
    grant_s          = '0;
    cand_s           = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_r} + IWP'(k);
      if (cand_s >= IWP'(N)) begin
        cand_s = cand_s - IWP'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && vld_ext_s[cand_s[IW-1:0]]) begin
        found_s = 1'b1;
        grant_s = cand_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Load decision, one-hot handshake, pointer advance and FSM next state.
  always_comb begin
    load_s    = ((state_r == EMPTY) || bus.out_rdy) && found_s;
    req_rdy_s = '0;
    for (int i = 0; i < N; i++) begin
      if (load_s && (grant_s == IW'(i))) begin
        req_rdy_s[i] = 1'b1;
      end else begin
        req_rdy_s[i] = 1'b0;
      end
    end
    if (grant_s == IW'(N - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = grant_s + IW'(1);
    end
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (load_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        // A load while full means consume and refill in the same cycle.
        if (load_s) begin
          state_nxt_s = FULL;
        end else if (bus.out_rdy) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output word, source index and priority pointer; all move only on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r      <= '0;
      out_data_r <= '0;
      out_src_r  <= '0;
    end else if (load_s) begin
      ptr_r      <= ptr_nxt_s;
      out_data_r <= bus.req_data[int'(grant_s)*W +: W];
      out_src_r  <= grant_s;
    end else begin
      ptr_r      <= ptr_r;
      out_data_r <= out_data_r;
      out_src_r  <= out_src_r;
    end
  end

  assign bus.req_rdy  = req_rdy_s;
  assign bus.out_vld  = (state_r == FULL);
  assign bus.out_data = out_data_r;
  assign bus.out_src  = out_src_r;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Directed vectors with hand-computed req_rdy patterns. Each expected grant
//   pushes the expected output word/source into a scoreboard queue; a monitor
//   pops and compares whenever the DUT output is valid and being consumed.
//   A second N=3 instance checks modulo-N wrap of the grant index.
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.N(4), .W(8), .IW(2)) bus ();
  mux_rr_arbiter #(.N(4), .W(8), .IW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux_rr_arbiter_if #(.N(3), .W(8), .IW(2)) bus3 ();
  mux_rr_arbiter #(.N(3), .W(8), .IW(2)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] src;
  } exp_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] dtab [4];
  exp_t       sb_q [$];
  logic [2:0] exp3_rdy [4];
  logic [1:0] exp3_src [4];
  logic [7:0] exp3_dat [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_data();
    for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = dtab[i];
  endtask

  // One cycle: drive after the rising edge, check req_rdy on the falling edge,
  // queue the expected output word for the granted requester.
  task automatic step(input logic [3:0] vld, input logic rdy, input logic [3:0] exp_rdy,
                      input string name);
    @(posedge clk);
    #1;
    bus.req_vld = vld;
    bus.out_rdy = rdy;
    load_data();
    @(negedge clk);
    check(name, 32'(bus.req_rdy), 32'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) sb_q.push_back({dtab[i], 2'(i)});
    end
  endtask

  // Scoreboard monitor: a word is consumed when out_vld && out_rdy.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_vld && bus.out_rdy) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: got data %0h src %0d expected no output",
                 bus.out_data, bus.out_src);
      end else begin
        e = sb_q.pop_front();
        check("mon_data", 32'(bus.out_data), 32'(e.data));
        check("mon_src", 32'(bus.out_src), 32'(e.src));
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_vld   = 4'b0000;
    bus.req_data  = 32'h0;
    bus.out_rdy   = 1'b0;
    bus3.req_vld  = 3'b000;
    bus3.req_data = 24'h0;
    bus3.out_rdy  = 1'b0;
    for (int i = 0; i < 4; i++) dtab[i] = 8'hA0 + 8'(i);
    exp3_rdy[0] = 3'b001; exp3_rdy[1] = 3'b010; exp3_rdy[2] = 3'b100; exp3_rdy[3] = 3'b001;
    exp3_src[0] = 2'd0;   exp3_src[1] = 2'd1;   exp3_src[2] = 2'd2;   exp3_src[3] = 2'd0;
    exp3_dat[0] = 8'hC0;  exp3_dat[1] = 8'hC1;  exp3_dat[2] = 8'hC2;  exp3_dat[3] = 8'hC0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_src", 32'(bus.out_src), 32'd0);
    check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    rst_n = 1'b1;

    // Fairness: all valid, grants 0,1,2,3,0
    step(4'b1111, 1'b1, 4'b0001, "rr_g0");
    step(4'b1111, 1'b1, 4'b0010, "rr_g1");
    step(4'b1111, 1'b1, 4'b0100, "rr_g2");
    step(4'b1111, 1'b1, 4'b1000, "rr_g3");
    step(4'b1111, 1'b1, 4'b0001, "rr_g0b");
    // Advance ptr to 3
    step(4'b1111, 1'b1, 4'b0010, "rr_g1b");
    step(4'b1111, 1'b1, 4'b0100, "rr_g2b");

    // Wrap search 3->0->1->2, only requester 2 valid
    dtab[2] = 8'h55;
    step(4'b0100, 1'b1, 4'b0100, "wrap_g2");
    step(4'b0100, 1'b1, 4'b0100, "wrap_g2b");

    // Backpressure: load 8'h11 from requester 3, then hold 5 cycles
    dtab[3] = 8'h11;
    step(4'b1000, 1'b1, 4'b1000, "bp_load");
    for (int c = 0; c < 5; c++) begin
      if (c == 2) dtab[3] = 8'h99;
      step(4'b1111, 1'b0, 4'b0000, "bp_rdy");
      check("bp_out_vld", 32'(bus.out_vld), 32'd1);
      check("bp_out_data", 32'(bus.out_data), 32'h11);
      check("bp_out_src", 32'(bus.out_src), 32'd3);
    end
    step(4'b1111, 1'b1, 4'b0001, "bp_release");

    // Single request from requester 1, then idle
    step(4'b0010, 1'b1, 4'b0010, "single");
    step(4'b0000, 1'b1, 4'b0000, "single_idle");
    check("single_vld_hi", 32'(bus.out_vld), 32'd1);
    step(4'b0000, 1'b1, 4'b0000, "single_gone");
    check("single_vld_lo", 32'(bus.out_vld), 32'd0);
    check("single_keep_data", 32'(bus.out_data), 32'hA1);
    check("single_keep_src", 32'(bus.out_src), 32'd1);

    // Async reset while full with ptr=2
    step(4'b0010, 1'b1, 4'b0010, "pre_rst");
    step(4'b0000, 1'b0, 4'b0000, "pre_rst_hold");
    check("pre_rst_vld", 32'(bus.out_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_vld", 32'(bus.out_vld), 32'd0);
    check("arst_out_data", 32'(bus.out_data), 32'h0);
    check("arst_out_src", 32'(bus.out_src), 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 4'b0001, "post_rst_g0");
    step(4'b0000, 1'b1, 4'b0000, "drain");

    // N=3 instance: grants 0,1,2,0
    bus3.req_data = {8'hC2, 8'hC1, 8'hC0};
    bus3.out_rdy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      bus3.req_vld = 3'b111;
      @(negedge clk);
      check("n3_rdy", 32'(bus3.req_rdy), 32'(exp3_rdy[k]));
      if (k > 0) begin
        check("n3_src", 32'(bus3.out_src), 32'(exp3_src[k-1]));
        check("n3_data", 32'(bus3.out_data), 32'(exp3_dat[k-1]));
      end
    end
    @(posedge clk);
    #1;
    bus3.req_vld = 3'b000;
    @(negedge clk);
    check("n3_src_last", 32'(bus3.out_src), 32'(exp3_src[3]));
    check("n3_data_last", 32'(bus3.out_data), 32'(exp3_dat[3]));

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
